// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller: load-use hazards, multdiv freeze and frame-synchronised STALLOP.
// Optional stall-cycle performance counter is built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned WAIT_FRAMES       = 1,
   parameter int unsigned PERF_W            = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       fd_ir,
   input  logic [31:0]       dx_ir,
   input  logic              pw_stall,
   input  logic              screen_end,
   output logic              stall,
   output logic              flush_dx,
   output logic              frame_wait,
   output logic [PERF_W-1:0] perf_stall_cnt
);

   localparam logic [4:0] OpLw    = 5'b01000;
   localparam logic [4:0] OpSw    = 5'b00111;
   localparam logic [4:0] OpBne   = 5'b00010;
   localparam logic [4:0] OpJr    = 5'b00100;
   localparam logic [4:0] OpBlt   = 5'b00110;
   localparam logic [4:0] OpBex   = 5'b10110;
   localparam logic [4:0] OpStall = 5'b11100;

   localparam int unsigned LdW = $clog2(LOAD_STALL_CYCLES + 1);
   localparam logic [LdW-1:0] LdReload = LdW'(LOAD_STALL_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StFrameWait, StRelease} frame_state_e;

   logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd;
   logic [4:0] src_a, src_b;
   logic       hazard;
   logic       ld_active, ld_stall;
   logic [LdW-1:0] ld_cnt_q, ld_cnt_d;

   frame_state_e state_q, state_d;
   logic [7:0]   fcnt_q, fcnt_d;
   logic [8:0]   fcnt_sum;
   logic         se_q, rise, frame_stall;
   logic         unused_bits;

   assign fd_op = fd_ir[31:27];
   assign fd_rd = fd_ir[26:22];
   assign fd_rs = fd_ir[21:17];
   assign fd_rt = fd_ir[16:12];
   assign dx_op = dx_ir[31:27];
   assign dx_rd = dx_ir[26:22];
   assign unused_bits = ^{fd_ir[11:0], dx_ir[21:0]};

   // BEX tests r30; stores and branches read their second operand from the rd field.
   assign src_a = (fd_op == OpBex) ? 5'd30 : fd_rs;
   assign src_b = (fd_op == OpSw || fd_op == OpBne || fd_op == OpJr || fd_op == OpBlt) ?
                  fd_rd : fd_rt;

   assign hazard = (dx_op == OpLw) && (dx_rd != 5'd0) && (fd_op != OpStall) &&
                   ((src_a == dx_rd) || ((src_b == dx_rd) && (fd_op != OpSw)));

   assign ld_active = (ld_cnt_q != '0);
   assign ld_stall  = ld_active | hazard;

   always_comb begin
      ld_cnt_d = ld_cnt_q;
      if (!pw_stall) begin
         if (ld_active) begin
            ld_cnt_d = ld_cnt_q - LdW'(1);
         end else if (hazard) begin
            ld_cnt_d = LdReload;
         end
      end
   end

   assign rise     = screen_end & ~se_q;
   assign fcnt_sum = {1'b0, fcnt_q} + {8'b0, rise};

   always_comb begin
      state_d     = state_q;
      fcnt_d      = fcnt_q;
      frame_stall = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fd_op == OpStall) begin
               frame_stall = 1'b1;
               state_d     = StFrameWait;
               fcnt_d      = '0;
            end
         end
         StFrameWait: begin
            frame_stall = 1'b1;
            fcnt_d      = fcnt_sum[7:0];
            if (fcnt_sum == 9'(WAIT_FRAMES)) begin
               state_d = StRelease;
            end
         end
         StRelease: begin
            // STALLOP only leaves FD once nothing else holds the pipe.
            if (!(pw_stall || ld_stall)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ld_cnt_q <= '0;
         state_q  <= StIdle;
         fcnt_q   <= '0;
         se_q     <= 1'b0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         se_q     <= screen_end;
      end
   end

   // Combinational requests are masked so the outputs stay quiet throughout reset.
   assign stall      = reset & (pw_stall | ld_stall | frame_stall);
   assign flush_dx   = reset & ld_stall & ~pw_stall;
   assign frame_wait = reset & (state_q == StFrameWait);

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] perf_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_q <= '0;
      end else if (stall && (perf_q != '1)) begin
         perf_q <= perf_q + 1'b1;
      end
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: dut_a (1 bubble, 1 frame, 16-bit perf),
// dut_b (3 bubbles, 2 frames, 4-bit perf).
module tb_hazard_stall_ctrl;

   localparam int OpAdd = 5'b00000;
   localparam int OpLw  = 5'b01000;
   localparam int OpSw  = 5'b00111;
   localparam int OpBne = 5'b00010;
   localparam int OpJr  = 5'b00100;
   localparam int OpBlt = 5'b00110;
   localparam int OpBex = 5'b10110;
   localparam int OpStl = 5'b11100;

`ifdef HAZARD_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic        clock, reset, pw_stall, screen_end;
   logic [31:0] a_fd, a_dx, b_fd, b_dx;
   logic        a_stall, a_flush, a_fw, b_stall, b_flush, b_fw;
   logic [15:0] a_perf;
   logic [3:0]  b_perf;
   int          n_checks = 0;
   int          n_errors = 0;

   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .WAIT_FRAMES(1), .PERF_W(16)) dut_a (
      .clock(clock), .reset(reset), .fd_ir(a_fd), .dx_ir(a_dx), .pw_stall(pw_stall),
      .screen_end(screen_end), .stall(a_stall), .flush_dx(a_flush), .frame_wait(a_fw),
      .perf_stall_cnt(a_perf)
   );

   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .WAIT_FRAMES(2), .PERF_W(4)) dut_b (
      .clock(clock), .reset(reset), .fd_ir(b_fd), .dx_ir(b_dx), .pw_stall(pw_stall),
      .screen_end(screen_end), .stall(b_stall), .flush_dx(b_flush), .frame_wait(b_fw),
      .perf_stall_cnt(b_perf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ins(int op, int rd, int rs, int rt);
      return {5'(op), 5'(rd), 5'(rs), 5'(rt), 12'b0};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic exp_stall, input logic exp_flush);
      check_eq({tag, "_stall"}, 32'(b_stall), 32'(exp_stall));
      check_eq({tag, "_flush"}, 32'(b_flush), 32'(exp_flush));
   endtask

   // Drives dut_a combinationally only; inputs return to nop before the edge.
   task automatic haz_vec(input string tag, input logic [31:0] dx, input logic [31:0] fd,
                          input logic exp);
      a_dx = dx;
      a_fd = fd;
      #1;
      check_eq(tag, 32'(a_flush), 32'(exp));
      a_dx = '0;
      a_fd = '0;
      tick();
   endtask

   initial begin
      reset = 1'b0; pw_stall = 1'b0; screen_end = 1'b0;
      a_fd = '0; a_dx = '0; b_fd = '0; b_dx = '0;
      #3;
      check_eq("rst_stall", 32'(b_stall), 32'd0);
      check_eq("rst_fw", 32'(b_fw), 32'd0);
      check_eq("rst_perf_b", 32'(b_perf), 32'd0);
      check_eq("rst_perf_a", 32'(a_perf), 32'd0);
      b_dx = ins(OpLw, 5, 0, 0); b_fd = ins(OpAdd, 1, 5, 2); pw_stall = 1'b1;
      #1;
      chk_b("rst_gate_b", 1'b0, 1'b0);
      check_eq("rst_gate_a", 32'(a_stall), 32'd0);
      pw_stall = 1'b0; b_dx = '0; b_fd = '0;
      tick(); tick();
      reset = 1'b1;
      tick();

      // Single-bubble load-use with pipeline model: DX becomes nop after the edge.
      a_dx = ins(OpLw, 5, 0, 0); a_fd = ins(OpAdd, 1, 5, 2);
      #1;
      check_eq("l1_c0_stall", 32'(a_stall), 32'd1);
      check_eq("l1_c0_flush", 32'(a_flush), 32'd1);
      tick();
      a_dx = '0;
      #1;
      check_eq("l1_c1_stall", 32'(a_stall), 32'd0);
      check_eq("l1_c1_flush", 32'(a_flush), 32'd0);
      a_fd = '0;
      tick();

      haz_vec("haz_rs",    ins(OpLw, 5, 0, 0),  ins(OpAdd, 1, 5, 2),  1'b1);
      haz_vec("haz_rt",    ins(OpLw, 9, 0, 0),  ins(OpAdd, 1, 2, 9),  1'b1);
      haz_vec("sw_rd",     ins(OpLw, 7, 0, 0),  ins(OpSw, 7, 3, 0),   1'b0);
      haz_vec("sw_base",   ins(OpLw, 6, 0, 0),  ins(OpSw, 2, 6, 0),   1'b1);
      haz_vec("rd_zero",   ins(OpLw, 0, 0, 0),  ins(OpAdd, 1, 0, 0),  1'b0);
      haz_vec("bex_r30",   ins(OpLw, 30, 0, 0), ins(OpBex, 0, 0, 0),  1'b1);
      haz_vec("jr_rd",     ins(OpLw, 7, 0, 0),  ins(OpJr, 7, 0, 0),   1'b1);
      haz_vec("blt_rd",    ins(OpLw, 6, 0, 0),  ins(OpBlt, 6, 1, 0),  1'b1);
      haz_vec("dx_not_lw", ins(OpSw, 5, 0, 0),  ins(OpAdd, 1, 5, 2),  1'b0);
      haz_vec("stallop",   ins(OpLw, 5, 0, 0),  ins(OpStl, 5, 5, 5),  1'b0);

      // Three-bubble load-use on a BNE.
      b_dx = ins(OpLw, 7, 0, 0); b_fd = ins(OpBne, 7, 1, 2);
      #1;
      chk_b("l3_c0", 1'b1, 1'b1);
      tick();
      b_dx = '0;
      #1;
      chk_b("l3_c1", 1'b1, 1'b1);
      tick();
      chk_b("l3_c2", 1'b1, 1'b1);
      tick();
      chk_b("l3_c3", 1'b0, 1'b0);
      b_dx = ins(OpLw, 7, 0, 0); b_fd = ins(OpSw, 7, 3, 0);
      #1;
      chk_b("l3_sw", 1'b0, 1'b0);
      b_dx = ins(OpLw, 0, 0, 0); b_fd = ins(OpAdd, 1, 0, 0);
      #1;
      chk_b("l3_r0", 1'b0, 1'b0);
      b_dx = '0; b_fd = '0;
      tick();

      // Multdiv freeze in the middle of a three-bubble stall.
      b_dx = ins(OpLw, 7, 0, 0); b_fd = ins(OpAdd, 1, 7, 0);
      #1;
      chk_b("pw_c0", 1'b1, 1'b1);
      tick();
      b_dx = '0; pw_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_b($sformatf("pw_frz%0d", i), 1'b1, 1'b0);
         tick();
      end
      pw_stall = 1'b0;
      #1;
      chk_b("pw_rem1", 1'b1, 1'b1);
      tick();
      chk_b("pw_rem2", 1'b1, 1'b1);
      tick();
      chk_b("pw_done", 1'b0, 1'b0);
      b_fd = '0;

      // Two-frame wait; screen_end already high on entry is not an edge.
      screen_end = 1'b1;
      tick();
      b_fd = ins(OpStl, 0, 0, 0);
      #1;
      check_eq("fw_entry_stall", 32'(b_stall), 32'd1);
      check_eq("fw_entry_fw", 32'(b_fw), 32'd0);
      tick();
      check_eq("fw_in_fw", 32'(b_fw), 32'd1);
      tick();
      check_eq("fw_level_hold", 32'(b_stall), 32'd1);
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      #1;
      check_eq("fw_rise1", 32'(b_stall), 32'd1);
      tick();
      check_eq("fw_after1_fw", 32'(b_fw), 32'd1);
      check_eq("fw_after1_stall", 32'(b_stall), 32'd1);
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      #1;
      check_eq("fw_rise2", 32'(b_stall), 32'd1);
      tick();
      check_eq("fw_release_stall", 32'(b_stall), 32'd0);
      check_eq("fw_release_fw", 32'(b_fw), 32'd0);
      b_fd = '0;
      tick();
      check_eq("fw_idle", 32'(b_stall), 32'd0);

      // Back-to-back STALLOP on the one-frame instance.
      a_fd = ins(OpStl, 0, 0, 0);
      #1;
      check_eq("b2b_entry", 32'(a_stall), 32'd1);
      tick();
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      #1;
      check_eq("b2b_fw", 32'(a_fw), 32'd1);
      tick();
      check_eq("b2b_release", 32'(a_stall), 32'd0);
      tick();
      check_eq("b2b_reenter_stall", 32'(a_stall), 32'd1);
      check_eq("b2b_reenter_fw", 32'(a_fw), 32'd0);
      tick();
      check_eq("b2b_fw2", 32'(a_fw), 32'd1);
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      tick();
      check_eq("b2b_release2", 32'(a_stall), 32'd0);
      a_fd = '0;
      tick();
      check_eq("b2b_idle", 32'(a_fw), 32'd0);

      // Reset mid-wait with one edge already counted.
      screen_end = 1'b0;
      b_fd = ins(OpStl, 0, 0, 0);
      tick();
      screen_end = 1'b1;
      tick();
      check_eq("mid_fw", 32'(b_fw), 32'd1);
      reset = 1'b0;
      #1;
      chk_b("mid_rst", 1'b0, 1'b0);
      check_eq("mid_rst_fw", 32'(b_fw), 32'd0);
      tick();
      reset = 1'b1;
      #1;
      check_eq("post_rst_stall", 32'(b_stall), 32'd1);
      tick();
      check_eq("post_rst_fw", 32'(b_fw), 32'd1);
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      tick();
      check_eq("post_rst_one_edge", 32'(b_stall), 32'd1);
      screen_end = 1'b0;
      tick();
      screen_end = 1'b1;
      tick();
      check_eq("post_rst_release", 32'(b_stall), 32'd0);
      b_fd = '0;
      tick();

      // Performance counter: 20 frozen cycles.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      pw_stall = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("perf_b_5", 32'(b_perf), PerfEn ? 32'd5 : 32'd0);
      for (int i = 0; i < 15; i++) tick();
      check_eq("perf_b_sat", 32'(b_perf), PerfEn ? 32'd15 : 32'd0);
      check_eq("perf_a_20", 32'(a_perf), PerfEn ? 32'd20 : 32'd0);
      pw_stall = 1'b0;
      tick();
      check_eq("perf_b_hold", 32'(b_perf), PerfEn ? 32'd15 : 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
